serial_word_deserializer: RTL and testbench
===========================================

Name: serial_word_deserializer

Overview:
Parametrised serial-to-parallel converter and successor to the fixed 1-to-7 ASCII converter. It assembles WIDTH-bit words from a qualified serial bit stream, MSB-first or LSB-first. The stream can be resynchronised at a frame boundary, and completed words are buffered in a small FIFO with a valid/ready output handshake. The block sits between a serial line front end and character-level consumers such as display or checker logic.

Parameters:
WIDTH, 7, bits per word (range 2..16)
MSB_FIRST, 1, 1 = first received bit is the word MSB; 0 = first received bit is the word LSB
FIFO_DEPTH, 4, output FIFO entries (power of 2, at least 2)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_bit  input  1  serial data bit
in_valid  input  1  in_bit is sampled on this edge when high
sync  input  1  frame restart: discard the partial word
out_data  output  WIDTH  word at the FIFO head
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data when out_valid && out_ready
fifo_count  output  log2(FIFO_DEPTH)+1  number of occupied entries
overflow  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (async assert, release synchronous to clk):
  - shift register = 0, bit counter = 0, FIFO empty.
  - out_valid = 0, out_data = 0, fifo_count = 0, overflow = 0.
  - Reset asserted mid-word or with a non-empty FIFO discards all data.
- Bit collection, on each edge with in_valid = 1:
  - MSB_FIRST = 1: shift left, new bit enters bit 0.
  - MSB_FIRST = 0: shift right, new bit enters bit WIDTH-1.
  - Bit counter increments 0..WIDTH-1 and wraps to 0 on the last bit.
  - in_valid = 0 holds all collection state.
- Word complete:
  - Occurs on the edge where in_valid = 1 and the bit counter = WIDTH-1.
  - The assembled word (shift register contents plus this bit) is the push candidate on that same edge.
- sync:
  - sync = 1 on an edge forces the bit counter to 0 and discards the partial word.
  - If in_valid = 1 on the same edge, that bit becomes bit 0 of the new word (counter = 1 afterwards).
  - sync never completes a word, even if the counter was WIDTH-1.
  - sync does not affect FIFO contents.
- FIFO:
  - Circular buffer with write and read pointers plus count.
  - out_data is the head entry; out_data is 0 when empty.
  - Pop occurs when out_valid && out_ready.
  - Push succeeds when not full, or when full with a pop on the same edge (count unchanged).
  - Push while full with no pop: word dropped, overflow set to 1 and held until reset.
  - Simultaneous push and pop when not full or empty: count unchanged.
  - Pop when empty: no effect.
- Latency:
  - Last bit sampled on edge N → out_valid = 1 and out_data = word after edge N, when the FIFO was empty.
  - Minimum bit-to-word latency is 1 cycle from the final bit.
- Throughput: one bit per cycle sustained; a word rate of one per WIDTH cycles never overflows when out_ready is held high.
- Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then WIDTH = 7, MSB_FIRST = 1, out_ready = 1, in_valid = 1, stream 1001000 1101001 → out_data 0x48 ('H') then 0x69 ('i'), each 1 cycle after its 7th bit; overflow = 0.
- MSB_FIRST = 0, stream 0001001 (first bit first) → out_data 0x48.
- Send 3 bits of garbage, pulse sync together with the first bit of 'A' (1000001), then 6 more bits → only 0x41 emitted; sync without in_valid gives the same result.
- out_ready = 0, send 5 words ('a'..'e') with FIFO_DEPTH = 4 → fifo_count saturates at 4, overflow = 1 after the 5th word completes; raise out_ready → 'a','b','c','d' drained in order, fifo_count returns to 0, overflow stays 1.
- FIFO full, and on the edge the next word completes out_ready = 1 → pop and push together; count stays 4, overflow stays 0, order preserved.
- Assert rst asynchronously mid-word with 2 words queued → out_valid, fifo_count, and overflow go to 0 immediately; the next full word after release is assembled from scratch.

Source files
------------

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: assembles WIDTH-bit words from a qualified bit stream into a small output FIFO
module serial_word_deserializer #(
    parameter int WIDTH      = 7,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_bit,
    input  logic                          in_valid,
    input  logic                          sync,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(WIDTH);
    logic [WIDTH-1:0] sr, base, word;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [CW-1:0]    cnt, cnt_next;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             done, pop, push;
    always_comb begin
        base      = sync ? '0 : sr;
        word      = MSB_FIRST ? {base[WIDTH-2:0], in_bit} : {in_bit, base[WIDTH-1:1]};
        done      = in_valid && !sync && cnt == CW'(WIDTH - 1);
        cnt_next  = !in_valid ? (sync ? '0 : cnt) : sync ? CW'(1) : done ? '0 : cnt + CW'(1);
        out_valid = fifo_count != '0;
        out_data  = out_valid ? mem[rd_ptr] : '0;
        pop       = out_valid && out_ready;
        push      = done && (fifo_count != CNTW'(FIFO_DEPTH) || pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            sr         <= in_valid ? word : base;
            cnt        <= cnt_next;
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_count <= fifo_count + CNTW'(push) - CNTW'(pop);
            overflow   <= overflow || (done && !push);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= word;
    end
endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb_serial_word_deserializer: directed self-checking bench for serial_word_deserializer
module tb_serial_word_deserializer;
    logic       clk = 1'b0;
    logic       rst, in_bit, in_valid, in_valid_l, sync, out_ready;
    logic [6:0] out_data, l_data;
    logic       out_valid, l_valid, overflow, l_overflow;
    logic [2:0] fifo_count, l_count;
    int         tests = 0;
    int         fails = 0;

    serial_word_deserializer #(.WIDTH(7), .MSB_FIRST(1'b1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .sync(sync),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    serial_word_deserializer #(.WIDTH(7), .MSB_FIRST(1'b0), .FIFO_DEPTH(4)) dut_l (
        .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid_l), .sync(sync),
        .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
        .fifo_count(l_count), .overflow(l_overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic b, input logic v, input logic s, input logic lsb);
        in_bit = b;
        sync   = s;
        if (lsb) in_valid_l = v;
        else in_valid = v;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_valid_l = 1'b0;
        sync       = 1'b0;
    endtask

    task automatic send_word(input logic [6:0] w, input logic lsb);
        for (int i = 0; i < 7; i++) step(lsb ? w[i] : w[6-i], 1'b1, 1'b0, lsb);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_bit = 0; in_valid = 0; in_valid_l = 0; sync = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        tests++; if (out_data !== 7'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", out_data); end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b0;
    endtask

    task automatic test_msb_first;
        out_ready = 1'b1;
        send_word(7'h48, 1'b0);
        tests++; if (out_valid !== 1'b1 || out_data !== 7'h48) begin fails++; $display("FAIL msb_H: got v=%b d=%h expected v=1 d=48", out_valid, out_data); end
        send_word(7'h69, 1'b0);
        tests++; if (out_valid !== 1'b1 || out_data !== 7'h69) begin fails++; $display("FAIL msb_i: got v=%b d=%h expected v=1 d=69", out_valid, out_data); end
        tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL msb_count: got %0d expected 1", fifo_count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL msb_overflow: got %b expected 0", overflow); end
        step(0, 0, 0, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL msb_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_lsb_first;
        send_word(7'h48, 1'b1);
        tests++; if (l_valid !== 1'b1 || l_data !== 7'h48) begin fails++; $display("FAIL lsb_H: got v=%b d=%h expected v=1 d=48", l_valid, l_data); end
    endtask

    task automatic sync_case(input int ng, input logic with_bit);
        logic [6:0] a = 7'h41;
        logic [9:0] b = 10'd0;
        int         n = 0;
        step(0, 0, 0, 0);
        for (int i = 0; i < ng; i++) begin
            step(1, 1, 0, 0);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sync_garbage%0d: got %b expected 0", ng, out_valid); end
        end
        if (!with_bit) begin
            step(0, 0, 1, 0);
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sync_only: got %b expected 0", out_valid); end
        end
        for (int i = 0; i < 7; i++) begin
            step(a[6-i], 1'b1, with_bit && i == 0, 1'b0);
            n++;
            tests++; if (out_valid !== (i == 6)) begin fails++; $display("FAIL sync_bit%0d_ng%0d: got %b expected %b", i, ng, out_valid, i == 6); end
        end
        b[0] = 1'b1;
        tests++; if (out_data !== a || fifo_count !== 3'd1) begin fails++; $display("FAIL sync_word_ng%0d: got d=%h c=%0d expected d=41 c=1", ng, out_data, fifo_count); end
        if (n != 7 || b[0] !== 1'b1) $fatal(1, "sync_case sequencing broken");
    endtask

    task automatic test_sync;
        out_ready = 1'b1;
        sync_case(3, 1'b1);
        sync_case(3, 1'b0);
        sync_case(6, 1'b1);
        step(0, 0, 0, 0);
    endtask

    task automatic test_overflow;
        logic [6:0] w;
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            w = 7'(7'h60 + k);
            send_word(w, 1'b0);
            tests++; if (fifo_count !== 3'(k > 4 ? 4 : k)) begin fails++; $display("FAIL ovf_count%0d: got %0d expected %0d", k, fifo_count, k > 4 ? 4 : k); end
            tests++; if (overflow !== (k == 5)) begin fails++; $display("FAIL ovf_flag%0d: got %b expected %b", k, overflow, k == 5); end
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            w = 7'(7'h60 + k);
            tests++; if (out_valid !== 1'b1 || out_data !== w) begin fails++; $display("FAIL ovf_drain%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, w); end
            step(0, 0, 0, 0);
        end
        tests++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL ovf_empty: got c=%0d v=%b expected c=0 v=0", fifo_count, out_valid); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_async_reset;
        logic [6:0] w = 7'h55;
        out_ready = 1'b0;
        send_word(7'h31, 1'b0);
        send_word(7'h32, 1'b0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        tests++; if (fifo_count !== 3'd2) begin fails++; $display("FAIL areset_pre: got %0d expected 2", fifo_count); end
        #2 rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin fails++; $display("FAIL areset_fifo: got v=%b c=%0d expected v=0 c=0", out_valid, fifo_count); end
        tests++; if (overflow !== 1'b0 || out_data !== 7'h00) begin fails++; $display("FAIL areset_flags: got o=%b d=%h expected o=0 d=00", overflow, out_data); end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(w[6-i], 1'b1, 1'b0, 1'b0);
            tests++; if (out_valid !== (i == 6)) begin fails++; $display("FAIL areset_bit%0d: got %b expected %b", i, out_valid, i == 6); end
        end
        tests++; if (out_data !== w) begin fails++; $display("FAIL areset_word: got %h expected 55", out_data); end
        step(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [6:0] w = 7'h14;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_word(7'(7'h10 + k), 1'b0);
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL b2b_full: got %0d expected 4", fifo_count); end
        for (int i = 0; i < 6; i++) step(w[6-i], 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        step(w[0], 1'b1, 1'b0, 1'b0);
        out_ready = 1'b0;
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL b2b_count: got %0d expected 4", fifo_count); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tests++; if (out_data !== 7'(7'h10 + k)) begin fails++; $display("FAIL b2b_order%0d: got %h expected %h", k, out_data, 7'(7'h10 + k)); end
            step(0, 0, 0, 0);
        end
        tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL b2b_empty: got %0d expected 0", fifo_count); end
    endtask

    initial begin
        test_reset;
        test_msb_first;
        test_lsb_first;
        test_sync;
        test_overflow;
        test_async_reset;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule
